ofmap_packer: RTL and testbench

Collects per-cycle column outputs from the 9x8 PE array and rebuilds them into 9-word packets, one packet per lane, for write-back. It performs the inverse of the feed-side buffers: those unpack a 9-word vector into one word per cycle, low word first; this block packs 9 consecutive beats back into a vector, first beat in the low word. Two banks (ping-pong) let capture of the next 9 beats overlap with draining of the previous packet set.

---
 rtl/ofmap_packer.sv | 119 +++++++++++
 tb/tb_ofmap_packer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_packer.sv
// Packs NUM_LANE-wide column beats into KERNEL_SIZE-word packets, one packet per lane,
// using two ping-pong banks so capture of the next beat set overlaps draining of the last.
module ofmap_packer #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 9,
  parameter int NUM_LANE    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_valid,
  output logic                              i_ready,
  input  logic [DATA_WIDTH*NUM_LANE-1:0]    i_data,
  output logic                              o_valid,
  input  logic                              o_ready,
  output logic [DATA_WIDTH*KERNEL_SIZE-1:0] o_data,
  output logic [$clog2(NUM_LANE)-1:0]       o_lane,
  output logic                              o_last
);

  localparam int BW = $clog2(KERNEL_SIZE);
  localparam int LW = $clog2(NUM_LANE);
  localparam logic [BW-1:0] LastBeat = BW'(KERNEL_SIZE - 1);
  localparam logic [LW-1:0] LastLane = LW'(NUM_LANE - 1);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e        state_q, state_d;
  logic          wrBank_q, wrBank_d;
  logic          rdBank_q, rdBank_d;
  logic [BW-1:0] beatCnt_q, beatCnt_d;
  logic [LW-1:0] laneCnt_q, laneCnt_d;
  logic [1:0]    full_q, full_d;
  logic          accept, fire, lastBeat, lastLane;

  logic [DATA_WIDTH-1:0] mem_q [2][KERNEL_SIZE][NUM_LANE];

  always_comb begin
    i_ready   = !rst && !full_q[wrBank_q];
    accept    = i_valid && i_ready;
    lastBeat  = (beatCnt_q == LastBeat);
    wrBank_d  = wrBank_q;
    beatCnt_d = beatCnt_q;
    if (accept) begin
      if (lastBeat) begin
        wrBank_d  = ~wrBank_q;
        beatCnt_d = '0;
      end else begin
        beatCnt_d = beatCnt_q + BW'(1);
      end
    end
  end

  // full_d folds in a same-cycle fill so a completed bank is drained with no bubble.
  always_comb begin
    o_valid  = (state_q == DRAIN);
    fire     = o_valid && o_ready;
    lastLane = (laneCnt_q == LastLane);
    full_d   = full_q;
    if (accept && lastBeat) full_d[wrBank_q] = 1'b1;
    if (fire && lastLane)   full_d[rdBank_q] = 1'b0;
    state_d   = state_q;
    rdBank_d  = rdBank_q;
    laneCnt_d = laneCnt_q;
    case (state_q)
      IDLE: begin
        if (full_d[rdBank_q]) state_d = DRAIN;
      end
      DRAIN: begin
        if (fire) begin
          if (lastLane) begin
            rdBank_d  = ~rdBank_q;
            laneCnt_d = '0;
            state_d   = full_d[~rdBank_q] ? DRAIN : IDLE;
          end else begin
            laneCnt_d = laneCnt_q + LW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_lane = laneCnt_q;
    o_last = o_valid && lastLane;
    o_data = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      o_data[k*DATA_WIDTH +: DATA_WIDTH] = o_valid ? mem_q[rdBank_q][k][laneCnt_q] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wrBank_q  <= 1'b0;
      rdBank_q  <= 1'b0;
      beatCnt_q <= '0;
      laneCnt_q <= '0;
      full_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      wrBank_q  <= wrBank_d;
      rdBank_q  <= rdBank_d;
      beatCnt_q <= beatCnt_d;
      laneCnt_q <= laneCnt_d;
      full_q    <= full_d;
    end
  end

  // Bank storage is never reset; o_data masking hides stale contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < NUM_LANE; l++) begin
        mem_q[wrBank_q][beatCnt_q][l] <= i_data[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_ofmap_packer.sv
// Scoreboard bench for ofmap_packer: expected packets are built from accepted beats
// and compared in order as the DUT hands packets out.
module tb_ofmap_packer;

  localparam int DW = 32;
  localparam int KS = 9;
  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [DW*NL-1:0] i_data = '0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [DW*KS-1:0] o_data;
  logic [2:0]    o_lane;
  logic          o_last;

  ofmap_packer #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .NUM_LANE(NL)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_lane(o_lane), .o_last(o_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW*KS-1:0] data;
    logic [2:0]       lane;
    logic             last;
  } pkt_t;

  pkt_t       expQ[$];
  logic [DW*NL-1:0] mdl [KS];
  int         mBeat = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         cycle = 0;
  string      curTest = "init";
  logic       obsIready, obsOvalid, obsLast, obsFire;
  logic [2:0] obsLane;
  logic [DW*KS-1:0] obsData;

  function automatic logic [DW*NL-1:0] beatWord(input int base, input int k);
    logic [DW*NL-1:0] w;
    for (int l = 0; l < NL; l++) w[l*DW +: DW] = DW'(base + 'h100 * k + l);
    return w;
  endfunction

  function automatic logic [DW*KS-1:0] laneWord(input int base, input int l);
    logic [DW*KS-1:0] w;
    for (int k = 0; k < KS; k++) w[k*DW +: DW] = DW'(base + 'h100 * k + l);
    return w;
  endfunction

  // One clock: drive at negedge, observe before the next posedge, update model and scoreboard.
  task automatic applyStimulus(input logic v, input logic [DW*NL-1:0] d, input logic ordy,
                               input logic r, output logic acc);
    pkt_t p, e;
    @(negedge clk);
    rst = r; i_valid = v; i_data = d; o_ready = ordy;
    #1;
    cycle++;
    obsIready = i_ready; obsOvalid = o_valid; obsLane = o_lane;
    obsLast = o_last; obsData = o_data;
    acc = v && i_ready;
    obsFire = o_valid && ordy && !r;
    if (obsFire) begin
      p.data = o_data; p.lane = o_lane; p.last = o_last;
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL %s unexpected_packet: got lane %0d last %b, want none", curTest, p.lane, p.last);
      end else begin
        e = expQ.pop_front();
        if (p !== e) begin
          miscompares++;
          $display("[TB] FAIL %s packet: got lane %0d last %b data %h, want lane %0d last %b data %h",
                   curTest, p.lane, p.last, p.data, e.lane, e.last, e.data);
        end
      end
    end
    if (r) begin
      mBeat = 0;
      expQ.delete();
    end else if (acc) begin
      mdl[mBeat] = d;
      mBeat++;
      if (mBeat == KS) begin
        for (int l = 0; l < NL; l++) begin
          for (int k = 0; k < KS; k++) e.data[k*DW +: DW] = mdl[k][l*DW +: DW];
          e.lane = 3'(l);
          e.last = (l == NL - 1);
          expQ.push_back(e);
        end
        mBeat = 0;
      end
    end
  endtask

  task automatic sendBeats(input int base, input int n, input logic ordy);
    int k = 0;
    int guard = 0;
    logic acc;
    while (k < n && guard < 10 * n + 20) begin
      applyStimulus(1'b1, beatWord(base, k), ordy, 1'b0, acc);
      if (acc) k++;
      guard++;
    end
    vectors++;
    if (k != n) begin
      miscompares++;
      $display("[TB] FAIL %s beats_accepted: got %0d want %0d", curTest, k, n);
    end
  endtask

  task automatic drainOut();
    int guard = 0;
    logic acc;
    while (expQ.size() > 0 && guard < 100) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
      guard++;
    end
  endtask

  task automatic test_reset();
    logic acc;
    curTest = "reset";
    applyStimulus(1'b0, '0, 1'b0, 1'b1, acc);
    vectors++;
    if (obsIready !== 1'b0 || obsOvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_handshake: got i_ready %b o_valid %b want 0 0", obsIready, obsOvalid);
    end
    vectors++;
    if (obsLane !== 3'd0 || obsLast !== 1'b0 || obsData !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got lane %0d last %b data %h want 0 0 0", obsLane, obsLast, obsData);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
    vectors++;
    if (obsIready !== 1'b1 || obsOvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got i_ready %b o_valid %b want 1 0", obsIready, obsOvalid);
    end
  endtask

  task automatic test_basic();
    int k = 0;
    int guard = 0;
    int lasts = 0;
    logic acc;
    logic [DW*KS-1:0] lane3 = '0;
    curTest = "basic";
    while (k < KS && guard < 40) begin
      applyStimulus(1'b1, beatWord(0, k), 1'b1, 1'b0, acc);
      if (acc) k++;
      guard++;
    end
    vectors++;
    if (obsOvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_early_valid: got o_valid %b want 0", obsOvalid);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    vectors++;
    if (obsOvalid !== 1'b1 || obsLane !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got o_valid %b lane %0d want 1 0", obsOvalid, obsLane);
    end
    guard = 0;
    while (expQ.size() > 0 && guard < 50) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
      if (obsFire && obsLane == 3'd3) lane3 = obsData;
      if (obsFire && obsLast) lasts++;
      guard++;
    end
    vectors++;
    if (lane3 !== laneWord(0, 3)) begin
      miscompares++;
      $display("[TB] FAIL basic_lane3: got %h want %h", lane3, laneWord(0, 3));
    end
    vectors++;
    if (lasts != 1 || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL basic_last_count: got %0d last, %0d pending want 1 0", lasts, expQ.size());
    end
  endtask

  task automatic test_streaming();
    int notReady = 0;
    int fires = 0;
    int firstFire = -1;
    int lastFire = -1;
    int k = 0;
    int guard = 0;
    logic acc;
    curTest = "streaming";
    while (guard < 80 && (k < 36 || expQ.size() > 0)) begin
      if (k < 36) begin
        applyStimulus(1'b1, beatWord('h500, k), 1'b1, 1'b0, acc);
        if (!obsIready) notReady++;
        if (acc) k++;
      end else begin
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
      end
      if (obsFire) begin
        fires++;
        if (firstFire < 0) firstFire = cycle;
        lastFire = cycle;
      end
      guard++;
    end
    vectors++;
    if (notReady != 0 || k != 36) begin
      miscompares++;
      $display("[TB] FAIL streaming_ready: got %0d stalls %0d beats want 0 36", notReady, k);
    end
    vectors++;
    if (fires != 32 || lastFire - firstFire != 34) begin
      miscompares++;
      $display("[TB] FAIL streaming_span: got %0d packets span %0d want 32 34", fires, lastFire - firstFire);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    curTest = "backpressure";
    sendBeats('h1000, 18, 1'b0);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, beatWord('h1000, 18), 1'b0, 1'b0, acc);
      vectors++;
      if (obsIready !== 1'b0 || obsOvalid !== 1'b1 || obsLane !== 3'd0) begin
        miscompares++;
        $display("[TB] FAIL bp_blocked: got i_ready %b o_valid %b lane %0d want 0 1 0", obsIready, obsOvalid, obsLane);
      end
    end
    for (int j = 0; j < 9; j++) begin
      applyStimulus(1'b1, beatWord('h1000, 18), 1'b1, 1'b0, acc);
      vectors++;
      if (obsIready !== (j == 8)) begin
        miscompares++;
        $display("[TB] FAIL bp_release_%0d: got i_ready %b want %b", j, obsIready, (j == 8));
      end
      if (acc) break;
    end
    for (int k = 19; k < 27; k++) begin
      int guard = 0;
      acc = 1'b0;
      while (!acc && guard < 20) begin
        applyStimulus(1'b1, beatWord('h1000, k), 1'b1, 1'b0, acc);
        guard++;
      end
    end
    drainOut();
    vectors++;
    if (expQ.size() != 0 || mBeat != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_complete: got %0d pending %0d partial want 0 0", expQ.size(), mBeat);
    end
  endtask

  task automatic test_gapped();
    int k = 0;
    logic acc;
    curTest = "gapped";
    for (int c = 0; c < 18; c++) begin
      if (c % 2 == 0) begin
        applyStimulus(1'b1, beatWord(0, k), 1'b1, 1'b0, acc);
        if (acc) k++;
      end else begin
        applyStimulus(1'b0, beatWord(0, 'h7f), 1'b1, 1'b0, acc);
      end
    end
    drainOut();
    vectors++;
    if (k != 9 || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL gapped_done: got %0d beats %0d pending want 9 0", k, expQ.size());
    end
  endtask

  task automatic test_stall();
    logic acc;
    curTest = "stall";
    sendBeats('h2000, 9, 1'b0);
    for (int j = 0; j < 4; j++) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    for (int j = 0; j < 5; j++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
      vectors++;
      if (obsLane !== 3'd4 || obsLast !== 1'b0 || obsOvalid !== 1'b1 || obsData !== laneWord('h2000, 4)) begin
        miscompares++;
        $display("[TB] FAIL stall_hold_%0d: got valid %b lane %0d last %b data %h want 1 4 0 %h",
                 j, obsOvalid, obsLane, obsLast, obsData, laneWord('h2000, 4));
      end
    end
    drainOut();
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stall_done: got %0d pending want 0", expQ.size());
    end
  endtask

  task automatic test_midreset();
    logic acc;
    curTest = "midreset";
    sendBeats('h3000, 6, 1'b1);
    applyStimulus(1'b1, beatWord('h3000, 6), 1'b1, 1'b1, acc);
    vectors++;
    if (obsIready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_ready: got i_ready %b want 0", obsIready);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    vectors++;
    if (obsOvalid !== 1'b0 || obsIready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_after: got o_valid %b i_ready %b want 0 1", obsOvalid, obsIready);
    end
    sendBeats('h4000, 9, 1'b1);
    drainOut();
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_done: got %0d pending want 0", expQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_streaming();
    test_backpressure();
    test_gapped();
    test_stall();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout at cycle %0d want completion", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
